vga_sync_porch: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_sync_to_count.sv | 55 +++++
 rtl/vga_sync_porch.sv | 125 ++++++++++++
 tb/tb_vga_sync_porch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 at 800x525 pixel clocks) and the types
// used by the sync/porch output stage.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_TOTAL_COLS       = 800;
  localparam int DEF_TOTAL_ROWS       = 525;
  localparam int DEF_ACTIVE_COLS      = 640;
  localparam int DEF_ACTIVE_ROWS      = 480;
  localparam int DEF_FRONT_PORCH_HORZ = 18;
  localparam int DEF_BACK_PORCH_HORZ  = 50;
  localparam int DEF_FRONT_PORCH_VERT = 10;
  localparam int DEF_BACK_PORCH_VERT  = 33;
  localparam int DEF_VIDEO_WIDTH      = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/vga_sync_to_count.sv
// Frame-start detector plus free-running column/row counters; the count held
// at cycle t labels the input sample taken at cycle t-1.
module vga_sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VSync,
  output cnt_t o_Col,
  output cnt_t o_Row,
  output logic o_Frame_Start,
  output logic o_Frame_Early
);

  localparam cnt_t LAST_COL = cnt_t'(TOTAL_COLS - 1);
  localparam cnt_t LAST_ROW = cnt_t'(TOTAL_ROWS - 1);

  logic r_vsync;
  logic frame_start;
  logic at_end;

  assign frame_start = i_VSync & ~r_vsync;
  assign at_end      = (o_Col == LAST_COL) && (o_Row == LAST_ROW);

  // Previous VSync resets high so a VSync already asserted at reset release
  // is not mistaken for a frame start.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_vsync       <= 1'b1;
      o_Col         <= '0;
      o_Row         <= '0;
      o_Frame_Start <= 1'b0;
      o_Frame_Early <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of its neighbours, independent of statement order.
      r_vsync       <= i_VSync;
      o_Frame_Start <= frame_start;
      o_Frame_Early <= frame_start & ~at_end;
      if (frame_start) begin
        o_Col <= '0;
        o_Row <= '0;
      end else if (o_Col == LAST_COL) begin
        o_Col <= '0;
        o_Row <= (o_Row == LAST_ROW) ? '0 : o_Row + 1'b1;
      end else begin
        o_Col <= o_Col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: converts the game's active-region flags into active-low
// syncs with porches, blanks video, and locks to the incoming frame start.
module vga_sync_porch
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_HORZ = DEF_FRONT_PORCH_HORZ,
  parameter int BACK_PORCH_HORZ  = DEF_BACK_PORCH_HORZ,
  parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
  parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT,
  parameter int VIDEO_WIDTH      = DEF_VIDEO_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Resync_Err
);

  localparam cnt_t H_ACTIVE     = cnt_t'(ACTIVE_COLS);
  localparam cnt_t V_ACTIVE     = cnt_t'(ACTIVE_ROWS);
  localparam cnt_t H_SYNC_START = cnt_t'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam cnt_t H_SYNC_END   = cnt_t'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam cnt_t V_SYNC_START = cnt_t'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam cnt_t V_SYNC_END   = cnt_t'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  cnt_t                   col, row;
  logic                   frame_start, frame_early;
  logic [VIDEO_WIDTH-1:0] r_red, r_grn, r_blu;
  lock_state_t            state, state_next;
  logic                   locked_next, hsync_next, vsync_next, resync_next;
  logic [VIDEO_WIDTH-1:0] red_next, grn_next, blu_next;

  // The column counter fully determines horizontal timing, so the game's
  // HSync flag carries no extra information; it stays on the port for drop-in use.
  logic unused_hsync;
  assign unused_hsync = i_HSync;

  vga_sync_to_count #(
    .TOTAL_COLS(TOTAL_COLS),
    .TOTAL_ROWS(TOTAL_ROWS)
  ) u_count (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_VSync      (i_VSync),
    .o_Col        (col),
    .o_Row        (row),
    .o_Frame_Start(frame_start),
    .o_Frame_Early(frame_early)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
    end else begin
      r_red <= i_Red_Video;
      r_grn <= i_Grn_Video;
      r_blu <= i_Blu_Video;
    end
  end

  // Outputs use the next state so the first locked pixel is the frame-start pixel.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next  = state;
    hsync_next  = 1'b1;
    vsync_next  = 1'b1;
    red_next    = '0;
    grn_next    = '0;
    blu_next    = '0;
    resync_next = 1'b0;

    if (state == UNLOCKED && frame_start) state_next = LOCKED;
    locked_next = (state_next == LOCKED);

    if (locked_next) begin
      hsync_next = !((col >= H_SYNC_START) && (col <= H_SYNC_END));
      vsync_next = !((row >= V_SYNC_START) && (row <= V_SYNC_END));
      if ((col < H_ACTIVE) && (row < V_ACTIVE)) begin
        red_next = r_red;
        grn_next = r_grn;
        blu_next = r_blu;
      end
    end
    if (state == LOCKED && frame_early) resync_next = 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= UNLOCKED;
      o_HSync      <= 1'b1;
      o_VSync      <= 1'b1;
      o_Red_Video  <= '0;
      o_Grn_Video  <= '0;
      o_Blu_Video  <= '0;
      o_Locked     <= 1'b0;
      o_Resync_Err <= 1'b0;
    end else begin
      state        <= state_next;
      o_HSync      <= hsync_next;
      o_VSync      <= vsync_next;
      o_Red_Video  <= red_next;
      o_Grn_Video  <= grn_next;
      o_Blu_Video  <= blu_next;
      o_Locked     <= locked_next;
      o_Resync_Err <= resync_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Directed bench: a default 800x525 instance and a 20-column instance are fed
// by bench-side game timing generators; outputs are labelled with the position
// driven two cycles earlier.
module tb_vga_sync_porch;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       d_hs, d_vs, n_hs, n_vs;
  logic [3:0] d_r, d_g, d_b, n_r, n_g, n_b;
  logic       o_hs, o_vs, o_lk, o_err;
  logic [3:0] o_r, o_g, o_b;
  logic       p_hs, p_vs, p_lk, p_err;
  logic [3:0] p_r, p_g, p_b;

  int errors = 0;
  int checks = 0;

  // Generator positions, and labels of the samples now visible at the outputs.
  int  gc, gr, nc, nr;
  int  d1c, d1r, oc, orw, nd1c, nd1r, noc, nrw;
  bit  freeze;

  always #5 clk = ~clk;

  vga_sync_porch u_dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_HSync(d_hs), .i_VSync(d_vs),
    .i_Red_Video(d_r), .i_Grn_Video(d_g), .i_Blu_Video(d_b),
    .o_HSync(o_hs), .o_VSync(o_vs),
    .o_Red_Video(o_r), .o_Grn_Video(o_g), .o_Blu_Video(o_b),
    .o_Locked(o_lk), .o_Resync_Err(o_err)
  );

  vga_sync_porch #(
    .TOTAL_COLS(20), .ACTIVE_COLS(10), .FRONT_PORCH_HORZ(2), .BACK_PORCH_HORZ(3)
  ) u_narrow (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_HSync(n_hs), .i_VSync(n_vs),
    .i_Red_Video(n_r), .i_Grn_Video(n_g), .i_Blu_Video(n_b),
    .o_HSync(p_hs), .o_VSync(p_vs),
    .o_Red_Video(p_r), .o_Grn_Video(p_g), .o_Blu_Video(p_b),
    .o_Locked(p_lk), .o_Resync_Err(p_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    d_hs = (gc < 640);
    d_vs = (gr < 480);
    d_r  = 4'hF;
    d_g  = gc[3:0];
    d_b  = gr[3:0];
    n_hs = (nc < 10);
    n_vs = (nr < 480);
    n_r  = 4'hF;
    n_g  = nc[3:0];
    n_b  = nr[3:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    oc  = d1c;  orw = d1r;  d1c  = gc; d1r  = gr;
    noc = nd1c; nrw = nd1r; nd1c = nc; nd1r = nr;
    if (!freeze) begin
      gc++;
      if (gc == 800) begin gc = 0; gr = (gr == 524) ? 0 : gr + 1; end
      nc++;
      if (nc == 20) begin nc = 0; nr = (nr == 524) ? 0 : nr + 1; end
    end
    drive();
  endtask

  task automatic wait_default(input string tag, input int c, input int r);
    int n = 0;
    while (!(oc == c && orw == r) && n < 2000) begin tick(); n++; end
    check(tag, (oc == c && orw == r), 1);
  endtask

  // One output line of the default instance, starting at output row 1.
  task automatic measure_line(input string tag);
    int hs_low = 0, hs_first = -1, red_on = 0, red_off = -1, vid_bad = 0, vs_low = 0;
    wait_default({tag, "_wait"}, 0, 1);
    for (int i = 0; i < 800; i++) begin
      if (!o_hs) begin hs_low++; if (hs_first < 0) hs_first = oc; end
      if (o_r == 4'hF) red_on++;
      else if (red_off < 0) red_off = oc;
      if (oc < 640 && (o_g !== oc[3:0] || o_b !== 4'h1)) vid_bad++;
      if (oc >= 640 && (o_g !== 4'h0 || o_b !== 4'h0)) vid_bad++;
      if (!o_vs) vs_low++;
      tick();
    end
    check({tag, "_hsync_low_clocks"}, hs_low, 92);
    check({tag, "_hsync_first_col"}, hs_first, 658);
    check({tag, "_red_on_clocks"}, red_on, 640);
    check({tag, "_red_first_blank_col"}, red_off, 640);
    check({tag, "_video_bad"}, vid_bad, 0);
    check({tag, "_vsync_low_clocks"}, vs_low, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, n, pulses, pcol, prow, drops;
    int vs_low, vs_row, vs_col, hs_low, hbad, vbad, vbad2, red_on, falls, t, t0, t1;
    logic prev_hs;

    rst_l = 1'b0;
    freeze = 1'b1;
    gc = 0; gr = 0; nc = 0; nr = 0;
    d1c = 0; d1r = 0; oc = 0; orw = 0; nd1c = 0; nd1r = 0; noc = 0; nrw = 0;
    drive();
    repeat (3) @(posedge clk);
    #2;
    check("reset_hsync", o_hs, 1);
    check("reset_vsync", o_vs, 1);
    check("reset_red", o_r, 0);
    check("reset_locked", o_lk, 0);
    check("reset_resync", o_err, 0);

    // VSync held high across reset release must not lock.
    @(negedge clk) rst_l = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (o_lk || p_lk || !o_hs || !o_vs || o_r != 0 || p_r != 0) bad++;
    end
    check("held_vsync_idle", bad, 0);

    // Approach a natural frame start: (0,0) is driven on the 10th tick.
    freeze = 1'b0;
    gc = 790; gr = 524; nc = 10; nr = 524;
    drive();
    bad = 0;
    repeat (10) begin
      tick();
      if (o_lk || !o_hs || !o_vs || o_r != 0 || o_g != 0) bad++;
    end
    check("prelock_idle", bad, 0);
    tick();
    check("lock_not_yet", o_lk, 0);
    tick();
    check("lock_rise", o_lk, 1);
    check("narrow_lock_rise", p_lk, 1);
    check("first_pixel_hsync", o_hs, 1);
    check("first_pixel_red", o_r, 4'hF);
    check("first_pixel_resync", o_err, 0);

    measure_line("line");

    // One full frame of the narrow instance, including its natural wrap.
    n = 0;
    while (!(noc == 0 && nrw == 0) && n < 11000) begin tick(); n++; end
    check("narrow_frame_wait", (noc == 0 && nrw == 0), 1);
    vs_low = 0; vs_row = -1; vs_col = -1; hs_low = 0; hbad = 0; vbad = 0; vbad2 = 0;
    red_on = 0; falls = 0; t0 = 0; t1 = 0; pulses = 0; drops = 0;
    prev_hs = p_hs;
    for (t = 0; t < 10500; t++) begin
      if (!p_vs) begin
        vs_low++;
        if (vs_row < 0) begin vs_row = nrw; vs_col = noc; end
      end
      if (!p_hs) hs_low++;
      if ((!p_hs) != (noc >= 12 && noc <= 16)) hbad++;
      if ((!p_vs) != (nrw >= 490 && nrw <= 491)) vbad++;
      if (noc < 10 && nrw < 480) begin
        if (p_r !== 4'hF || p_g !== noc[3:0] || p_b !== nrw[3:0]) vbad2++;
      end else if (p_r !== 4'h0 || p_g !== 4'h0 || p_b !== 4'h0) vbad2++;
      if (p_r == 4'hF) red_on++;
      if (prev_hs && !p_hs) begin
        if (falls == 0) t0 = t;
        if (falls == 1) t1 = t;
        falls++;
      end
      prev_hs = p_hs;
      if (p_err) pulses++;
      if (!p_lk) drops++;
      tick();
    end
    check("narrow_vsync_low_clocks", vs_low, 40);
    check("narrow_vsync_first_row", vs_row, 490);
    check("narrow_vsync_first_col", vs_col, 0);
    check("narrow_hsync_low_clocks", hs_low, 2625);
    check("narrow_hsync_cols_bad", hbad, 0);
    check("narrow_vsync_rows_bad", vbad, 0);
    check("narrow_video_bad", vbad2, 0);
    check("narrow_red_on_clocks", red_on, 4800);
    check("narrow_line_period", t1 - t0, 20);
    check("narrow_wrap_no_resync", pulses, 0);
    check("narrow_lock_held", drops, 0);

    // Early frame start mid-line on the default instance.
    n = 0;
    while (oc != 300 && n < 900) begin tick(); n++; end
    check("resync_wait", oc, 300);
    gc = 795; gr = 524;
    drive();
    pulses = 0; pcol = -1; prow = -1; drops = 0;
    repeat (40) begin
      tick();
      if (o_err) begin pulses++; pcol = oc; prow = orw; end
      if (!o_lk) drops++;
    end
    check("resync_pulses", pulses, 1);
    check("resync_pulse_col", pcol, 0);
    check("resync_pulse_row", prow, 0);
    check("resync_lock_held", drops, 0);
    measure_line("post_resync");

    // Asynchronous reset between clock edges in the middle of a line.
    n = 0;
    while (oc != 300 && n < 900) begin tick(); n++; end
    check("pre_reset_red", o_r, 4'hF);
    #2 rst_l = 1'b0;
    #1;
    check("async_reset_red", o_r, 0);
    check("async_reset_locked", o_lk, 0);
    check("async_reset_hsync", o_hs, 1);
    check("async_reset_vsync", o_vs, 1);
    @(negedge clk) rst_l = 1'b1;
    tick();
    gc = 795; gr = 524;
    drive();
    bad = 0;
    repeat (5) begin tick(); if (o_lk) bad++; end
    check("relock_idle", bad, 0);
    tick();
    check("relock_not_yet", o_lk, 0);
    tick();
    check("relock_rise", o_lk, 1);
    check("relock_no_resync", o_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
